uart_tx_buffered: RTL
=====================

# uart_tx_buffered

Buffered 8N1 UART transmitter: the transmit half of the UART controller, the counterpart of `UART_RECEIVER`. It accepts bytes from the controller/OS side into a small FIFO and serialises them on `tx` as start bit, 8 data bits LSB-first, and stop bit. Back-to-back queued bytes go out with no idle gap. It runs on the 50 MHz board clock and shares the bit timing of the receive path.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (9600 baud at 50 MHz). Must be ≥ 2.
- `WORD_SIZE`, default 8: data bits per frame.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: reset, synchronous and active-high.
- `data`, input, WORD_SIZE: byte to enqueue.
- `write_data`, input, 1: enqueue strobe, sampled each rising edge.
- `tx`, output, 1: serial line, registered, idle high.
- `busy`, output, 1: high while a frame is on the line.
- `empty`, output, 1: FIFO holds no entries.
- `full`, output, 1: FIFO holds DEPTH entries.
- `tx_done`, output, 1: one-cycle pulse when a stop bit completes.
- `overflow`, output, 1: one-cycle pulse when a write is dropped.

## Operation

- **Reset values (all outputs):** `tx`=1, `busy`=0, `empty`=1, `full`=0, `tx_done`=0, `overflow`=0. FIFO count and pointers are 0; state is IDLE.
- **FIFO**
  - Circular buffer with read and write pointers of width log2(DEPTH); pointers wrap modulo DEPTH.
  - The count register is log2(DEPTH)+1 bits.
  - `full` and `empty` are decoded from the registered count.
- **Write**
  - `write_data`=1 with `full`=0: store `data` at the write pointer and advance the pointer.
  - `write_data`=1 with `full`=1: the byte is dropped and `overflow` pulses the next cycle. This holds even if a pop occurs the same cycle.
- **Simultaneous push and pop** (not full): both happen, count is unchanged, and the data is preserved in order.
- **FSM states:**
  - IDLE: `tx`=1. If `empty`=0, pop the head into the shift register, clear the bit counter, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After WORD_SIZE bits, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1, is reset on every state or bit change, and has width clog2(CLKS_PER_BIT).
- **busy:** `busy` = (state ≠ IDLE).
- **Reset mid-frame:** the frame is aborted, `tx` returns to 1 at the reset edge, and the FIFO is flushed (queued bytes are lost).
- **Data capture:** `data` is captured only at the write edge; later changes on `data` do not affect queued bytes.

## Timing

- **Write-to-line latency:** a write sampled at edge k into an empty FIFO in IDLE gives `empty`=0 after edge k, and `tx`=0 and `busy`=1 after edge k+1.
- **Frame length:** exactly (WORD_SIZE+2)·CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- **Back-to-back frames:**
  - The next start bit begins on the cycle immediately after the last stop-bit cycle.
  - The frame period is exactly (WORD_SIZE+2)·CLKS_PER_BIT cycles.
  - `busy` stays high throughout.
- **tx_done:** high for one cycle, coincident with the final stop-bit cycle.
- **busy after the last frame:** `busy` falls one cycle after `tx_done` when the FIFO is empty.
- **Flag update:** `full` and `empty` update the cycle after the push/pop edge.
- **Slot release:** a pop at edge k frees a slot for a write at edge k+1.

## Test plan

1. **Single byte.** CLKS_PER_BIT=4: reset, then write 0x55 once. Required: `tx` = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. `tx_done` pulses on cycle 40 of the frame; `busy` is high for 40 cycles; `empty` returns to 1 after the pop.
2. **Burst with overflow.** DEPTH=4, consecutive-cycle writes 0x01,0x02,0x03,0x04,0x05,0x06. Required: the first byte is popped into the shifter, so 0x02–0x05 fill the FIFO; `full`=1; 0x06 is dropped with one `overflow` pulse. Frames carry 0x01..0x05 in order with zero idle cycles between them, and there are 5 `tx_done` pulses.
3. **Simultaneous write and pop.** Write a byte on the exact cycle STOP pops the FIFO. Required: count is unchanged, no byte is lost, and order is preserved.
4. **Reset mid-frame.** Assert `rst` during DATA bit 3 with 2 bytes queued. Required: `tx`=1, `busy`=0, `empty`=1 after that edge. No further frames are sent and no `tx_done` pulse occurs.
5. **Loopback to the receiver.** Connect `tx` to `UART_RECEIVER.rx` with the default baud and send 0xA5, then 0x3C. Required: the receiver raises `enable_data_interrupt` twice, with `data`=0xA5 then 0x3C.
6. **Write while full, with data change.** Hold `write_data`=1 for DEPTH+2 cycles while `data` changes every cycle. Required: exactly DEPTH+1 bytes are accepted (1 in the shifter, DEPTH in the FIFO), one `overflow` pulse per rejected cycle, and the transmitted values equal `data` as sampled on the accepted edges.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter. Bytes written from the controller side are
// queued in a small circular FIFO and serialised on tx as one start bit,
// WORD_SIZE data bits (LSB first) and one stop bit. Queued bytes follow each
// other with no idle gap on the line.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous, active-high reset
//   data       byte to enqueue, captured on the write edge
//   write_data enqueue strobe, sampled each rising edge
//   tx         serial line, registered, idle high
//   busy       high while a frame is on the line
//   empty      FIFO holds no entries
//   full       FIFO holds DEPTH entries
//   tx_done    one-cycle pulse during the final stop-bit cycle
//   overflow   one-cycle pulse the cycle after a write is dropped
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | WORD_SIZE data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1); pops the next byte straight into START if queued

module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int WORD_SIZE    = 8,
    parameter int DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 write_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 empty,
    output logic                 full,
    output logic                 tx_done,
    output logic                 overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = $clog2(WORD_SIZE + 1);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE   = BW'(CLKS_PER_BIT - 2);
    localparam logic [NW-1:0] BIT_LAST   = NW'(WORD_SIZE - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [WORD_SIZE-1:0] shift;
    logic [WORD_SIZE-1:0] shift_next;
    logic [BW-1:0]        baud;
    logic [NW-1:0]        bit_cnt;
    logic                 baud_end;
    logic                 push;
    logic                 pop;

    assign empty      = (count == '0);
    assign full       = (count == COUNT_FULL);
    assign busy       = (state != IDLE);
    assign baud_end   = (baud == BAUD_LAST);
    assign shift_next = shift >> 1;

    // A write while full is dropped even if a pop frees a slot on the same
    // edge: the decision uses the registered count only.
    assign push = write_data && !full;
    assign pop  = !empty && ((state == IDLE) || ((state == STOP) && baud_end));

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= write_data && full;
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer; tx is registered so it reflects the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        baud    <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + NW'(1);
                            tx      <= shift_next[0];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    // Raised one edge early so the registered pulse lines up
                    // with the final stop-bit cycle.
                    if (baud == BAUD_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_end) begin
                        baud <= '0;
                        if (!empty) begin
                            shift   <= mem[rd_ptr];
                            bit_cnt <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
